// File: rtl/bvule_shl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bvule_shl_pkg : shared types for the bvule/bvshl witness checker |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bvule_shl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int SHIFT_CNT_W = $clog2(DEF_WIDTH + 1);

  // Shift counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int shift_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bvule_shl_witness_checker_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bvule_shl_witness_checker_if : query in / verdict out handshake  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface bvule_shl_witness_checker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] in_t;
  logic [WIDTH-1:0] in_x;
  logic             out_valid;
  logic             out_ready;
  logic             out_sat;
  logic [WIDTH-1:0] out_shifted;

  modport master (
    output in_valid, in_s, in_t, in_x, out_ready,
    input  in_ready, out_valid, out_sat, out_shifted
  );

  modport slave (
    input  in_valid, in_s, in_t, in_x, out_ready,
    output in_ready, out_valid, out_sat, out_shifted
  );
endinterface
`default_nettype wire

// File: rtl/bvule_shl_witness_checker_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bvule_shl_witness_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bvule_shl_witness_checker : bit-serial x<<s, then (x<<s) <=u t   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bvule_shl_witness_checker
  import bvule_shl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bvule_shl_witness_checker_if.slave   bus,
  output logic [CNT_W-1:0]             check_count,
  output logic [CNT_W-1:0]             fail_count
);

  localparam int               KW    = shift_cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] S_MAX = WIDTH'(WIDTH);
  localparam logic [KW-1:0]    K_MAX = KW'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] t_q;
  logic [KW-1:0]    k;
  logic             sat_q;
  logic [WIDTH-1:0] shifted_q;

  logic [KW-1:0]    k_init;
  logic             handshake;

  // Shifts of WIDTH or more clear the vector, so clamp the count there.
  assign k_init    = (bus.in_s >= S_MAX) ? K_MAX : KW'(bus.in_s);
  assign handshake = (state == DONE) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      t_q       <= '0;
      k         <= '0;
      sat_q     <= 1'b0;
      shifted_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            t_q   <= bus.in_t;
            sr    <= bus.in_x;
            k     <= k_init;
            state <= (k_init != '0) ? SHIFT : CMP;
          end
        end
        SHIFT: begin
          sr <= sr << 1;
          k  <= k - 1'b1;
          if (k == KW'(1)) begin
            state <= CMP;
          end
        end
        CMP: begin
          sat_q     <= (sr <= t_q);
          shifted_q <= sr;
          state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.out_sat     = sat_q;
  assign bus.out_shifted = shifted_q;

  sat_counter #(.CNT_W(CNT_W)) u_check_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handshake),
    .count (check_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handshake && !sat_q),
    .count (fail_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_bvule_shl_witness_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bvule_shl_witness_checker : directed vectors + corner cases   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_bvule_shl_witness_checker;

  logic clk;
  logic rst_n;

  logic [15:0] check_count, fail_count;
  logic [1:0]  check_count_s, fail_count_s;

  bvule_shl_witness_checker_if #(.WIDTH(4)) bus  ();
  bvule_shl_witness_checker_if #(.WIDTH(4)) bus2 ();

  // Second instance (2-bit counters) runs the same stimulus in lockstep.
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_s      = bus.in_s;
  assign bus2.in_t      = bus.in_t;
  assign bus2.in_x      = bus.in_x;
  assign bus2.out_ready = bus.out_ready;

  bvule_shl_witness_checker #(.WIDTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .check_count (check_count),
    .fail_count  (fail_count)
  );

  bvule_shl_witness_checker #(.WIDTH(4), .CNT_W(2)) dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus2),
    .check_count (check_count_s),
    .fail_count  (fail_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s;
    logic [3:0] t;
    logic [3:0] x;
    logic [3:0] exp_shifted;
    logic       exp_sat;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  int n_assert = 0;
  int n_fail   = 0;

  int exp_checks   = 0;
  int exp_fails    = 0;
  int exp_checks_s = 0;
  int exp_fails_s  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_s     = s;
    bus.in_t     = t;
    bus.in_x     = x;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the captured query must be unaffected.
    bus.in_valid = 1'b0;
    bus.in_s     = ~s;
    bus.in_t     = ~t;
    bus.in_x     = ~x;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic model_delivered(input logic sat);
    exp_checks++;
    if (!sat) exp_fails++;
    if (exp_checks_s < 3) exp_checks_s++;
    if (!sat && exp_fails_s < 3) exp_fails_s++;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_check_count"},   32'(check_count),   32'(exp_checks));
    chk({tag, "_fail_count"},    32'(fail_count),    32'(exp_fails));
    chk({tag, "_check_count_s"}, 32'(check_count_s), 32'(exp_checks_s));
    chk({tag, "_fail_count_s"},  32'(fail_count_s),  32'(exp_fails_s));
  endtask

  initial begin
    int lat;
    logic [3:0] held_shifted;
    logic       held_sat;
    int         seen_valid;

    //            s      t      x      shifted sat lat
    vecs[0] = '{4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 1};
    vecs[1] = '{4'h1, 4'h5, 4'h3, 4'h6, 1'b0, 2};
    vecs[2] = '{4'h2, 4'h4, 4'h1, 4'h4, 1'b1, 3};
    vecs[3] = '{4'h5, 4'h0, 4'hF, 4'h0, 1'b1, 5};
    vecs[4] = '{4'h3, 4'hF, 4'h3, 4'h8, 1'b1, 4};
    vecs[5] = '{4'h0, 4'h7, 4'h8, 4'h8, 1'b0, 1};
    vecs[6] = '{4'h2, 4'hB, 4'h3, 4'hC, 1'b0, 3};
    vecs[7] = '{4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 5};
    vecs[8] = '{4'h1, 4'h0, 4'h1, 4'h2, 1'b0, 2};
    vecs[9] = '{4'h0, 4'hE, 4'hF, 4'hF, 1'b0, 1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_s      = '0;
    bus.in_t      = '0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",    32'(bus.in_ready),    32'd1);
    chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
    chk("rst_out_sat",     32'(bus.out_sat),     32'd0);
    chk("rst_out_shifted", 32'(bus.out_shifted), 32'd0);
    check_counters("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].s, vecs[i].t, vecs[i].x);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat),             32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_shifted", i), 32'(bus.out_shifted), 32'(vecs[i].exp_shifted));
      chk($sformatf("v%0d_sat", i),     32'(bus.out_sat),     32'(vecs[i].exp_sat));
      chk($sformatf("v%0d_in_ready_done", i), 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      model_delivered(vecs[i].exp_sat);
      chk($sformatf("v%0d_valid_drop", i), 32'(bus.out_valid), 32'd0);
      check_counters($sformatf("v%0d", i));
    end
    // Five failing queries so far: the 2-bit fail counter must sit at 3.
    chk("small_fail_saturated", 32'(fail_count_s), 32'd3);

    // Backpressure: hold the result for 10 cycles with a rival query pending.
    bus.out_ready = 1'b0;
    send(4'h2, 4'h4, 4'h1);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd3);
    held_shifted = bus.out_shifted;
    held_sat     = bus.out_sat;
    chk("bp_shifted", 32'(held_shifted), 32'h4);
    chk("bp_sat",     32'(held_sat),     32'd1);
    bus.in_valid = 1'b1;
    bus.in_s     = 4'h0;
    bus.in_t     = 4'h0;
    bus.in_x     = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid),   32'd1);
      chk($sformatf("bp%0d_in_ready", c),  32'(bus.in_ready),    32'd0);
      chk($sformatf("bp%0d_shifted", c),   32'(bus.out_shifted), 32'(held_shifted));
      chk($sformatf("bp%0d_sat", c),       32'(bus.out_sat),     32'(held_sat));
      check_counters($sformatf("bp%0d", c));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    model_delivered(1'b1);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check_counters("bp_release");
    seen_valid = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid++;
    end
    chk("bp_rival_ignored", 32'(seen_valid), 32'd0);
    check_counters("bp_after");

    // Asynchronous reset while shifting an s=3 query.
    send(4'h3, 4'hF, 4'h3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_checks = 0; exp_fails = 0; exp_checks_s = 0; exp_fails_s = 0;
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_counters("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid++;
    end
    chk("midrst_no_result", 32'(seen_valid), 32'd0);
    check_counters("midrst_after");

    // Counters restart from zero after reset.
    send(4'h0, 4'hF, 4'hF);
    wait_valid(lat);
    chk("post_rst_latency", 32'(lat),             32'd1);
    chk("post_rst_shifted", 32'(bus.out_shifted), 32'hF);
    @(posedge clk);
    #1;
    model_delivered(1'b1);
    check_counters("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/bvule_shl_witness_checker.md
# bvule_shl_witness_checker

Sequential checker for the 4-bit `bvule`/`bvshl` invertibility Skolem functions. It accepts a query `(s, t)` and a candidate witness `x`, and computes `x << s` one bit per cycle. It then decides whether `(x << s) <=u t` holds and keeps running totals of checks and failures. It sits downstream of the combinational Skolem-function netlists, closing the loop from witness generation to witness validation in the verification harness.

## Interface
- `WIDTH`, default 4: bit-vector width of s, t and x.
- `CNT_W`, default 16: width of the statistics counters.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: query present on `in_s`/`in_t`/`in_x`.
- `in_ready` out, 1: block can accept a query.
- `in_s` in, WIDTH: shift amount.
- `in_t` in, WIDTH: upper bound.
- `in_x` in, WIDTH: candidate witness.
- `out_valid` out, 1: result available.
- `out_ready` in, 1: consumer takes the result.
- `out_sat` out, 1: 1 when `(x << s) <=u t`.
- `out_shifted` out, WIDTH: computed `x << s`, truncated to WIDTH.
- `check_count` out, CNT_W: number of results delivered; saturates.
- `fail_count` out, CNT_W: number of delivered results with `out_sat=0`; saturates.

## Operation
- FSM states: IDLE, SHIFT, CMP, DONE.
- `in_ready` = (state == IDLE). One query is outstanding at a time.
- IDLE, on `in_valid`:
  - capture `t`;
  - load the shift register with `x`;
  - set the count `k = min(s, WIDTH)`;
  - go to SHIFT if `k != 0`, else go to CMP.
- SHIFT, each cycle:
  - shift register ← `{sr[WIDTH-2:0], 1'b0}`;
  - k ← k−1;
  - go to CMP when k reaches 0.
- Shift semantics follow SMT-LIB: `s >= WIDTH` yields 0, so every such query is satisfiable.
- CMP:
  - `out_sat` ← `(sr <=u t)`, an unsigned comparison;
  - `out_shifted` ← `sr`;
  - go to DONE.
- DONE:
  - `out_valid`=1, and `out_sat`/`out_shifted` are held stable until `out_ready`;
  - on `out_valid & out_ready`: increment `check_count`, increment `fail_count` if `!out_sat`, go to IDLE.
  - There is no same-cycle re-accept, because `in_ready` is low in DONE.
- Counters saturate at all-ones and never wrap.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_sat`=0, `out_shifted`=0, both counters 0.
- Reset asserted mid-operation: the query is dropped with no result, and the counters are cleared.

## Timing
- Define k = min(s, WIDTH).
- Acceptance edge E0 is the edge where `in_valid & in_ready`.
- `out_valid` is first high after edge E0+k+1, giving latency k+1 cycles. The range is 1 (s=0) to WIDTH+1.
- Throughput is one query per k+3 cycles with `out_ready` held high: k+1 cycles of latency, one DONE cycle, one IDLE cycle.
- Inputs are sampled only at E0; changes to `in_*` afterwards have no effect.
- Counters update on the edge of the output handshake and are visible in the following cycle.

## Structure
- Package `bvule_shl_pkg`:
  - `state_t` enum {IDLE, SHIFT, CMP, DONE};
  - localparam for the shift-count width, `$clog2(WIDTH+1)`.
- Sub-module `sat_counter`, parameterised on CNT_W, with an `inc` input and saturating behaviour. It is instantiated twice, once per counter.
- The comparator is inline; no separate module.

## Test plan
All scenarios use WIDTH=4.
- s=0, t=0xF, x=0xF → `out_shifted`=0xF, `out_sat`=1, `out_valid` 1 cycle after accept.
- s=1, t=5, x=3 → `out_shifted`=6, `out_sat`=0, latency 2, `fail_count` 0→1 after the handshake.
- s=2, t=4, x=1 → `out_shifted`=4, `out_sat`=1 (equality boundary), latency 3.
- s=5, t=0, x=0xF → k=4, `out_shifted`=0, `out_sat`=1, latency 5.
- Backpressure: `out_ready` low for 10 cycles while in DONE:
  - `out_valid` stays high and outputs stay stable;
  - `in_ready` stays low;
  - a new `in_valid` is ignored;
  - counters change exactly once after `out_ready`.
- CNT_W=2 with 5 failing queries → `fail_count` saturates at 3.
- `rst_n` pulsed during SHIFT of s=3 → immediate IDLE, `in_ready`=1, no `out_valid`, counters 0.
